// File: rtl/multi_trigger_if.sv
// rtl/multi_trigger_if.sv - handshake, consensus and actor bus of one multi_trigger
//
// Purpose: groups every non-clock/reset signal of multi_trigger.
//   master : the trigger itself (drives actor starts, status and fire_count)
//   slave  : the surrounding partition (host handshake, sibling consensus, actors)
// Signals:
//   ap_start/ap_done/ap_idle/ap_ready       host block-level handshake
//   all_sleep/all_sync_sleep/all_waited     AND-reduced consensus from all triggers
//   sleep/sync_sleep/waited                 this trigger's contribution to consensus
//   actor_return[2*N_ACTORS]                per-actor return code, actor i at [2i+1:2i]
//   actor_done/actor_idle/actor_start       per-actor handshake
//   fire_count[CNT_W]                       productive firings since last start
interface multi_trigger_if #(
   parameter int N_ACTORS = 4,
   parameter int CNT_W    = 32
);
   logic                    ap_start;
   logic                    ap_done;
   logic                    ap_idle;
   logic                    ap_ready;
   logic                    all_sleep;
   logic                    all_sync_sleep;
   logic                    all_waited;
   logic                    sleep;
   logic                    sync_sleep;
   logic                    waited;
   logic [2*N_ACTORS-1:0]   actor_return;
   logic [N_ACTORS-1:0]     actor_done;
   logic [N_ACTORS-1:0]     actor_idle;
   logic [N_ACTORS-1:0]     actor_start;
   logic [CNT_W-1:0]        fire_count;

   modport master (
      input  ap_start, all_sleep, all_sync_sleep, all_waited,
      input  actor_return, actor_done, actor_idle,
      output ap_done, ap_idle, ap_ready, sleep, sync_sleep, waited,
      output actor_start, fire_count
   );

   modport slave (
      output ap_start, all_sleep, all_sync_sleep, all_waited,
      output actor_return, actor_done, actor_idle,
      input  ap_done, ap_idle, ap_ready, sleep, sync_sleep, waited,
      input  actor_start, fire_count
   );
endinterface

// File: rtl/multi_trigger.sv
// rtl/multi_trigger.sv - round-based scheduler for the HLS actors of one partition
//
// Purpose: launches every actor once per round, tracks WAIT returns, sleeps after
//   WAIT_THRESHOLD consecutive all-WAIT rounds and joins the sleep / sync-sleep /
//   waited consensus with sibling triggers. Counts productive (non-WAIT) firings.
// Ports:
//   ap_clk  in  clock, rising edge
//   ap_rst  in  synchronous reset, active-high
//   bus     multi_trigger_if.master (host handshake, consensus, actor signals, fire_count)
module multi_trigger #(
   parameter int N_ACTORS       = 4,
   parameter int WAIT_THRESHOLD = 2,
   parameter int CNT_W          = 32
) (
   input  logic             ap_clk,
   input  logic             ap_rst,
   multi_trigger_if.master  bus
);
   localparam int SW   = $clog2(WAIT_THRESHOLD + 1);
   localparam int PW   = $clog2(N_ACTORS + 1);
   localparam int SUMW = ((CNT_W > PW) ? CNT_W : PW) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [1:0]       RET_WAIT = 2'b01;

   typedef enum logic [2:0] {
      S_IDLE, S_LAUNCH, S_SLEEP, S_SYNC_LAUNCH, S_SYNC_SLEEP
   } state_t;

   state_t              state_q, state_d;
   logic [N_ACTORS-1:0] round_done_q, round_done_d;
   logic [N_ACTORS-1:0] last_waited_q, last_waited_d;
   logic                round_exec_q, round_exec_d;
   logic [SW-1:0]       streak_q, streak_d;
   logic [CNT_W-1:0]    fire_count_q, fire_count_d;
   logic                ap_done_q, ap_done_d;

   logic                run;
   logic                round_end;
   logic                round_wait;
   logic                streak_hit;
   logic [N_ACTORS-1:0] done_run;
   logic [N_ACTORS-1:0] done_wait;
   logic [PW-1:0]       fired;
   logic [SUMW-1:0]     sum;

   assign run       = (state_q == S_LAUNCH) || (state_q == S_SYNC_LAUNCH);
   // Completions only count while a round is running.
   assign done_run  = run ? bus.actor_done : '0;
   assign round_end = run && (&(round_done_q | bus.actor_done));
   // An executed return recorded earlier in the round or in this cycle breaks the WAIT round.
   assign round_wait = !round_exec_q && !(|(done_run & ~done_wait));
   assign streak_hit = (int'(streak_q) + 1) >= WAIT_THRESHOLD;

   always_comb begin
      done_wait = '0;
      fired     = '0;
      for (int i = 0; i < N_ACTORS; i++) begin
         done_wait[i] = (bus.actor_return[2*i +: 2] == RET_WAIT);
         fired        = fired + PW'(done_run[i] & ~done_wait[i]);
      end
      sum = SUMW'(fire_count_q) + SUMW'(fired);
   end

   // State and datapath registers
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q       <= S_IDLE;
         round_done_q  <= '0;
         last_waited_q <= '0;
         round_exec_q  <= 1'b0;
         streak_q      <= '0;
         fire_count_q  <= '0;
         ap_done_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         round_done_q  <= round_done_d;
         last_waited_q <= last_waited_d;
         round_exec_q  <= round_exec_d;
         streak_q      <= streak_d;
         fire_count_q  <= fire_count_d;
         ap_done_q     <= ap_done_d;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.ap_start) state_d = S_LAUNCH;
         end
         S_LAUNCH: begin
            if (round_end && round_wait && streak_hit && bus.all_waited) state_d = S_SLEEP;
         end
         S_SLEEP: begin
            // Global sleep wins over a sibling that became busy again.
            if (bus.all_sleep)        state_d = S_SYNC_LAUNCH;
            else if (!bus.all_waited) state_d = S_LAUNCH;
         end
         S_SYNC_LAUNCH: begin
            if (round_end) state_d = S_SYNC_SLEEP;
         end
         S_SYNC_SLEEP: begin
            if (bus.all_sync_sleep) begin
               if (!bus.all_waited)          state_d = S_LAUNCH;
               else if (&bus.actor_idle)     state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Next datapath values
   always_comb begin
      round_done_d  = round_end ? '0 : (round_done_q | done_run);
      round_exec_d  = round_end ? 1'b0 : (round_exec_q | (|(done_run & ~done_wait)));
      last_waited_d = (last_waited_q & ~done_run) | (done_run & done_wait);

      streak_d = streak_q;
      if ((state_q == S_LAUNCH) && round_end) begin
         if (!round_wait)                            streak_d = '0;
         else if (streak_q != SW'(WAIT_THRESHOLD))   streak_d = streak_q + SW'(1);
      end
      if (((state_q == S_SLEEP) || (state_q == S_IDLE)) && (state_d == S_LAUNCH))
         streak_d = '0;

      fire_count_d = fire_count_q;
      if ((state_q == S_IDLE) && bus.ap_start)
         fire_count_d = '0;
      else if (run)
         fire_count_d = (sum > SUMW'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];

      ap_done_d = (state_q == S_SYNC_SLEEP) && (state_d == S_IDLE);
   end

   // Outputs
   always_comb begin
      bus.actor_start = run ? (~round_done_q & ~bus.actor_done) : '0;
      bus.ap_idle     = (state_q == S_IDLE);
      bus.sleep       = (state_q == S_IDLE) || (state_q == S_SLEEP);
      bus.sync_sleep  = (state_q == S_IDLE) || (state_q == S_SYNC_SLEEP);
      bus.waited      = &last_waited_q;
      bus.ap_done     = ap_done_q;
      bus.ap_ready    = ap_done_q;
      bus.fire_count  = fire_count_q;
   end
endmodule

// File: tb/tb_multi_trigger.sv
// tb/tb_multi_trigger.sv - directed and randomized bench for multi_trigger
module tb_multi_trigger;
   localparam int N  = 4;
   localparam int TH = 2;

   logic ap_clk;
   logic ap_rst;

   multi_trigger_if #(.N_ACTORS(N), .CNT_W(32)) m_if ();
   multi_trigger_if #(.N_ACTORS(N), .CNT_W(2))  s_if ();

   multi_trigger #(.N_ACTORS(N), .WAIT_THRESHOLD(TH), .CNT_W(32)) dut (
      .ap_clk (ap_clk),
      .ap_rst (ap_rst),
      .bus    (m_if.master)
   );

   multi_trigger #(.N_ACTORS(N), .WAIT_THRESHOLD(TH), .CNT_W(2)) dut_narrow (
      .ap_clk (ap_clk),
      .ap_rst (ap_rst),
      .bus    (s_if.master)
   );

   assign s_if.ap_start       = m_if.ap_start;
   assign s_if.all_sleep      = m_if.all_sleep;
   assign s_if.all_sync_sleep = m_if.all_sync_sleep;
   assign s_if.all_waited     = m_if.all_waited;
   assign s_if.actor_return   = m_if.actor_return;
   assign s_if.actor_done     = m_if.actor_done;
   assign s_if.actor_idle     = m_if.actor_idle;

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Stimulus for the coming cycle
   logic       r_rst, r_start, r_as, r_ass, r_aw;
   logic [3:0] r_done, r_idle;
   logic [7:0] r_ret;

   // Reference model: scheduler state described by the rules, not by the RTL encoding
   typedef enum {M_IDLE, M_LAUNCH, M_SLEEP, M_SYNC_LAUNCH, M_SYNC_SLEEP} mstate_t;
   mstate_t    ms;
   logic [3:0] m_rdone;
   logic [3:0] m_lastw;
   int         m_round_exec;
   int         m_streak;
   longint     m_fires;
   bit         m_done_pulse;

   task automatic model_reset();
      ms           = M_IDLE;
      m_rdone      = '0;
      m_lastw      = '0;
      m_round_exec = 0;
      m_streak     = 0;
      m_fires      = 0;
      m_done_pulse = 0;
   endtask

   function automatic logic [5:0] exp_flags();
      return {ms == M_IDLE, ms == M_IDLE || ms == M_SLEEP, ms == M_IDLE || ms == M_SYNC_SLEEP,
              &m_lastw, m_done_pulse, m_done_pulse};
   endfunction

   task automatic defaults();
      r_rst = 0; r_start = 0; r_as = 0; r_ass = 0; r_aw = 0;
      r_done = '0; r_idle = 4'hF; r_ret = '0;
   endtask

   // One clock cycle: apply inputs, compare against the model, advance the model
   task automatic step();
      bit         run, complete, rwait;
      int         nexec;
      logic [3:0] e_start;
      mstate_t    nx;
      @(negedge ap_clk);
      ap_rst              = r_rst;
      m_if.ap_start       = r_start;
      m_if.all_sleep      = r_as;
      m_if.all_sync_sleep = r_ass;
      m_if.all_waited     = r_aw;
      m_if.actor_done     = r_done;
      m_if.actor_idle     = r_idle;
      m_if.actor_return   = r_ret;
      #1;
      run = (ms == M_LAUNCH) || (ms == M_SYNC_LAUNCH);
      for (int i = 0; i < N; i++) e_start[i] = run && !m_rdone[i] && !r_done[i];
      check("start", m_if.actor_start, e_start);
      check("start_n", s_if.actor_start, e_start);
      check("flags", {m_if.ap_idle, m_if.sleep, m_if.sync_sleep, m_if.waited, m_if.ap_done, m_if.ap_ready}, exp_flags());
      check("flags_n", {s_if.ap_idle, s_if.sleep, s_if.sync_sleep, s_if.waited, s_if.ap_done, s_if.ap_ready}, exp_flags());
      check("fire_count", m_if.fire_count, (m_fires > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_fires);
      check("fire_count_n", s_if.fire_count, (m_fires > 3) ? 3 : m_fires);

      if (r_rst) begin
         model_reset();
      end else begin
         nexec    = 0;
         complete = run;
         for (int i = 0; i < N; i++) begin
            if (run && r_done[i] && r_ret[2*i +: 2] != 2'b01) nexec++;
            if (!(m_rdone[i] || r_done[i])) complete = 0;
         end
         rwait = (m_round_exec + nexec) == 0;
         nx = ms;
         case (ms)
            M_IDLE:        if (r_start) nx = M_LAUNCH;
            M_LAUNCH:      if (complete && rwait && (m_streak + 1 >= TH) && r_aw) nx = M_SLEEP;
            M_SLEEP:       if (r_as) nx = M_SYNC_LAUNCH; else if (!r_aw) nx = M_LAUNCH;
            M_SYNC_LAUNCH: if (complete) nx = M_SYNC_SLEEP;
            M_SYNC_SLEEP: begin
               if (r_ass && !r_aw) nx = M_LAUNCH;
               else if (r_ass && r_aw && r_idle == 4'hF) nx = M_IDLE;
            end
            default: nx = ms;
         endcase
         if (ms == M_IDLE && r_start) m_fires = 0;
         else if (run)                m_fires += nexec;
         for (int i = 0; i < N; i++)
            if (run && r_done[i]) m_lastw[i] = (r_ret[2*i +: 2] == 2'b01);
         if (complete) begin
            m_rdone      = '0;
            m_round_exec = 0;
         end else if (run) begin
            m_rdone      = m_rdone | r_done;
            m_round_exec += nexec;
         end
         if (ms == M_LAUNCH && complete) m_streak = rwait ? m_streak + 1 : 0;
         if (nx == M_LAUNCH && (ms == M_SLEEP || ms == M_IDLE)) m_streak = 0;
         m_done_pulse = (ms == M_SYNC_SLEEP) && (nx == M_IDLE);
         ms = nx;
      end
   endtask

   initial begin
      int pw[4];
      logic [1:0] code;
      pw = '{95, 60, 100, 30};

      defaults();
      ap_rst = 1;
      m_if.ap_start = 0; m_if.all_sleep = 0; m_if.all_sync_sleep = 0; m_if.all_waited = 0;
      m_if.actor_done = '0; m_if.actor_idle = 4'hF; m_if.actor_return = '0;
      repeat (2) @(posedge ap_clk);
      model_reset();

      // Reset state
      r_rst = 1; step();
      check("rst_start", m_if.actor_start, 4'h0);
      check("rst_sleep", {m_if.sleep, m_if.sync_sleep, m_if.ap_idle}, 3'b111);
      check("rst_waited", m_if.waited, 1'b0);
      check("rst_done", {m_if.ap_done, m_if.ap_ready}, 2'b00);

      // T1: WAIT threshold of two rounds
      defaults(); r_start = 1; step();
      defaults(); r_aw = 1; step();
      check("t1_first_start", m_if.actor_start, 4'hF);
      r_done = 4'hF; r_ret = 8'h55; step();
      check("t1_no_restart", m_if.actor_start, 4'h0);
      r_done = 0; step();
      check("t1_r1_no_sleep", m_if.sleep, 1'b0);
      check("t1_relaunch", m_if.actor_start, 4'hF);
      r_done = 4'hF; step();
      r_done = 0; step();
      check("t1_r2_sleep", {m_if.sleep, m_if.sync_sleep, m_if.actor_start}, {2'b10, 4'h0});

      // T3: sibling busy again -> LAUNCH with streak cleared
      r_aw = 0; step();
      r_aw = 1; step();
      check("t3_back_launch", {m_if.sleep, m_if.actor_start}, {1'b0, 4'hF});
      r_done = 4'hF; r_ret = 8'h55; step();
      r_done = 0; step();
      check("t3_streak_cleared", m_if.sleep, 1'b0);

      // T2: actor 2 done three cycles late
      r_done = 4'b1011; r_ret = 8'h00; step();
      r_done = 0;
      for (int k = 0; k < 3; k++) begin
         step();
         check("t2_hold", m_if.actor_start, 4'b0100);
      end
      r_done = 4'b0100; r_ret = 8'h10; step();
      check("t2_done_cycle", m_if.actor_start, 4'h0);
      r_done = 0; step();
      check("t2_all_restart", m_if.actor_start, 4'hF);

      // Two WAIT rounds back to SLEEP
      r_ret = 8'h55;
      for (int k = 0; k < 2; k++) begin
         r_done = 4'hF; step();
         r_done = 0; step();
      end
      check("sleep_again", m_if.sleep, 1'b1);

      // T3 cont: all_sleep beats ~all_waited
      r_as = 1; r_aw = 0; step();
      r_as = 0; r_aw = 1; step();
      check("t3_sync_launch", {m_if.sleep, m_if.sync_sleep, m_if.actor_start}, {2'b00, 4'hF});
      r_done = 4'hF; step();
      r_done = 0; step();
      check("sync_sleep_entered", {m_if.sleep, m_if.sync_sleep}, 2'b01);

      // T4: join waits for every actor idle
      r_ass = 1; r_aw = 1; r_idle = 4'b1011; step();
      r_idle = 4'hF; step();
      check("t4_stay", {m_if.ap_idle, m_if.sync_sleep}, 2'b01);
      defaults(); step();
      check("t4_done", {m_if.ap_done, m_if.ap_ready, m_if.ap_idle}, 3'b111);
      step();
      check("t4_done_once", m_if.ap_done, 1'b0);

      // T5: saturation of the 2-bit counter
      r_start = 1; step();
      defaults(); step();
      check("t5_clear", s_if.fire_count, 2'd0);
      r_done = 4'b0011; step();
      r_done = 0; step();
      check("t5_two", s_if.fire_count, 2'd2);
      r_done = 4'b1100; step();
      r_done = 0; step();
      check("t5_sat", s_if.fire_count, 2'd3);
      check("t5_wide", m_if.fire_count, 32'd4);

      // T6: reset in the middle of a round
      r_done = 4'hF; r_ret = 8'h55; step();
      r_done = 4'b0001; step();
      check("t6_start1", m_if.actor_start[1], 1'b1);
      check("t6_waited_pre", m_if.waited, 1'b1);
      r_rst = 1; r_done = 0; step();
      defaults(); step();
      check("t6_start_off", m_if.actor_start, 4'h0);
      check("t6_idle", {m_if.ap_idle, m_if.sleep}, 2'b11);
      check("t6_waited", m_if.waited, 1'b0);
      check("t6_fire_count", m_if.fire_count, 32'd0);

      // Randomized phases with different WAIT densities
      for (int ph = 0; ph < 4; ph++) begin
         for (int c = 0; c < 600; c++) begin
            r_rst   = ($urandom_range(0, 299) == 0);
            r_start = ($urandom_range(0, 3) == 0);
            r_as    = ($urandom_range(0, 9) == 0);
            r_ass   = ($urandom_range(0, 3) != 0);
            r_aw    = ($urandom_range(0, 9) < ((ph == 1) ? 5 : 9));
            r_done  = 4'($urandom & $urandom);
            r_idle  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            for (int i = 0; i < N; i++) begin
               if ($urandom_range(0, 99) < pw[ph]) begin
                  code = 2'b01;
               end else begin
                  code = 2'($urandom_range(0, 2));
                  if (code == 2'b01) code = 2'b11;
               end
               r_ret[2*i +: 2] = code;
            end
            step();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
